// File: rtl/nerv_dmem_dma.sv
// Word-granular copy/fill DMA engine driving the core's dmem initiator port.
// One word per RD/LAT/WR trip for copy, one word per WR cycle for fill.
module nerv_dmem_dma #(
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stall,
    input  logic                 i_start,
    input  logic                 i_mode,
    input  logic [31:0]          i_src_addr,
    input  logic [31:0]          i_dst_addr,
    input  logic [LEN_WIDTH-1:0] i_len,
    input  logic [31:0]          i_pattern,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic                 o_dmem_valid,
    output logic [31:0]          o_dmem_addr,
    output logic [3:0]           o_dmem_wstrb,
    output logic [31:0]          o_dmem_wdata,
    input  logic [31:0]          i_dmem_rdata
);

    typedef enum logic [2:0] {StIdle, StRd, StLat, StWr, StFin} state_t;

    state_t                r_state;
    logic [31:0]           r_src;
    logic [31:0]           r_dst;
    logic [31:0]           r_pattern;
    logic [31:0]           r_buf;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic                  r_mode;
    logic                  r_error;

    logic w_misaligned;
    logic w_issue;

    // Fill never reads, so only its destination alignment matters.
    assign w_misaligned = (!i_mode && (i_src_addr[1:0] != 2'b00)) ||
                          (i_dst_addr[1:0] != 2'b00);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_src     <= 32'h0;
            r_dst     <= 32'h0;
            r_pattern <= 32'h0;
            r_buf     <= 32'h0;
            r_rem     <= '0;
            r_mode    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_error <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        if (w_misaligned) begin
                            r_error <= 1'b1;
                        end else if (i_len == '0) begin
                            r_state <= StFin;
                        end else begin
                            r_src     <= i_src_addr;
                            r_dst     <= i_dst_addr;
                            r_rem     <= i_len;
                            r_mode    <= i_mode;
                            r_pattern <= i_pattern;
                            r_state   <= i_mode ? StWr : StRd;
                        end
                    end
                end
                StRd: begin
                    if (!i_stall) r_state <= StLat;
                end
                // Read data is only valid this one cycle, so stall cannot hold it.
                StLat: begin
                    r_buf   <= i_dmem_rdata;
                    r_state <= StWr;
                end
                StWr: begin
                    if (!i_stall) begin
                        r_src <= r_src + 32'd4;
                        r_dst <= r_dst + 32'd4;
                        r_rem <= r_rem - LEN_WIDTH'(1);
                        if (r_rem == LEN_WIDTH'(1)) begin
                            r_state <= StFin;
                        end else begin
                            r_state <= r_mode ? StWr : StRd;
                        end
                    end
                end
                StFin: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign w_issue      = ((r_state == StRd) || (r_state == StWr)) && !i_stall;
    assign o_dmem_valid = w_issue;
    assign o_dmem_addr  = (r_state == StWr) ? r_dst : r_src;
    assign o_dmem_wstrb = (w_issue && (r_state == StWr)) ? 4'b1111 : 4'b0000;
    assign o_dmem_wdata = r_mode ? r_pattern : r_buf;
    assign o_busy       = (r_state == StRd) || (r_state == StLat) || (r_state == StWr);
    assign o_done       = (r_state == StFin);
    assign o_error      = r_error;

endmodule

// File: tb/tb_nerv_dmem_dma.sv
// Scoreboard bench for nerv_dmem_dma: a transaction-list model predicts dmem traffic and
// completion events; a negedge monitor pops and compares whatever the DUT presents.
module tb_nerv_dmem_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, start, mode;
    logic [31:0] src, dst, pattern, rdata;
    logic [15:0] len;
    logic        busy, done, error, dv;
    logic [31:0] daddr, wdata;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    nerv_dmem_dma #(.LEN_WIDTH(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_start(start), .i_mode(mode),
        .i_src_addr(src), .i_dst_addr(dst), .i_len(len), .i_pattern(pattern),
        .o_busy(busy), .o_done(done), .o_error(error), .o_dmem_valid(dv),
        .o_dmem_addr(daddr), .o_dmem_wstrb(wstrb), .o_dmem_wdata(wdata),
        .i_dmem_rdata(rdata)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [1:0]  ev_q[$];     // 1 = done, 2 = error
    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          n_cmp = 0, n_fail = 0, n_valid = 0, n_wr = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hC3A5_5A3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory target: read data appears in the cycle after the request only.
    always @(posedge clk) begin
        rdata <= $urandom;
        if (rst_n && dv) begin
            if (wstrb == 4'h0) rdata <= mem.exists(daddr) ? mem[daddr] : dflt(daddr);
            else mem[daddr] = wdata;
        end
    end

    always @(negedge clk) begin : mon
        txn_t e;
        if (rst_n) begin
            if (dv) begin
                n_valid++;
                if (wstrb != 4'h0) n_wr++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_dmem: got addr %h wstrb %h want no traffic",
                             daddr, wstrb);
                end else begin
                    e = exp_q.pop_front();
                    check("dmem_addr", daddr, e.addr);
                    check("dmem_wstrb", {28'h0, wstrb}, e.wr ? 32'hF : 32'h0);
                    if (e.wr) check("dmem_wdata", wdata, e.data);
                end
            end
            if (done || error) begin
                if (ev_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_event: got done=%0b error=%0b want none",
                             done, error);
                end else begin
                    check("event", {30'h0, error, done}, {30'h0, ev_q.pop_front()});
                end
            end
        end
    end

    // Reference: a command is an ordered list of word reads/writes, then one event.
    task automatic model(input logic m, input logic [31:0] s, input logic [31:0] d,
                         input logic [15:0] n, input logic [31:0] p);
        logic [31:0] sa, da, wd;
        if ((!m && s[1:0] != 2'b00) || d[1:0] != 2'b00) begin
            ev_q.push_back(2'd2);
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            sa = s + 32'(4 * i);
            da = d + 32'(4 * i);
            if (!m) begin
                exp_q.push_back('{wr: 1'b0, addr: sa, data: 32'h0});
                wd = ref_mem.exists(sa) ? ref_mem[sa] : dflt(sa);
            end else begin
                wd = p;
            end
            exp_q.push_back('{wr: 1'b1, addr: da, data: wd});
            ref_mem[da] = wd;
        end
        ev_q.push_back(2'd1);
    endtask

    // Called at posedge+1. stall_cnt < 0 means random stall throughout.
    task automatic run_cmd(input logic m, input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] n, input logic [31:0] p,
                           input int stall_from, input int stall_cnt, output int cyc);
        logic exp_busy;
        exp_busy = !((!m && s[1:0] != 2'b00) || d[1:0] != 2'b00) && (n != 16'h0);
        model(m, s, d, n, p);
        start = 1'b1; mode = m; src = s; dst = d; len = n; pattern = p;
        @(posedge clk); #1;
        start = 1'b0;
        mode = 1'($urandom); src = $urandom; dst = $urandom;
        len = 16'($urandom); pattern = $urandom;
        cyc = 1;
        check("busy_after_accept", {31'h0, busy}, {31'h0, exp_busy});
        while (!(done || error) && cyc < 400) begin
            start = busy && ($urandom_range(0, 2) == 0);
            if (stall_cnt < 0) stall = ($urandom_range(0, 2) == 0);
            else stall = (cyc >= stall_from) && (cyc < stall_from + stall_cnt);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        stall = 1'b0;
        if (!(done || error)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: got no done/error after %0d cycles want completion", cyc);
        end
        if (done) check("busy_with_done", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;
        check("pulse_width", {30'h0, done, error}, 32'h0);
    endtask

    initial begin
        int cyc, base, k, n, exp_cyc;
        logic m, rs;
        logic [31:0] s, d;

        rst_n = 1'b0; stall = 1'b0; start = 1'b0; mode = 1'b0;
        src = 32'h0; dst = 32'h0; len = 16'h0; pattern = 32'h0;
        for (int i = 0; i < 4; i++) begin
            mem[32'h100 + 32'(4 * i)]     = 32'(i + 1);
            ref_mem[32'h100 + 32'(4 * i)] = 32'(i + 1);
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {27'h0, busy, done, error, dv, |wstrb}, 32'h0);

        // Copy issued in the same slot reset releases: accepted on the first edge.
        rst_n = 1'b1;
        n_valid = 0;
        run_cmd(1'b0, 32'h100, 32'h200, 16'd4, 32'h0, 0, 0, cyc);
        check("copy_cycles", cyc, 32'd13);
        check("copy_valid_cycles", n_valid, 32'd8);
        for (int i = 0; i < 4; i++) check("copy_mem", mem[32'h200 + 32'(4 * i)], 32'(i + 1));

        run_cmd(1'b1, 32'h3, 32'h300, 16'd3, 32'hDEADBEEF, 0, 0, cyc);
        check("fill_cycles", cyc, 32'd4);

        n_valid = 0;
        run_cmd(1'b0, 32'h100, 32'h202, 16'd2, 32'h0, 0, 0, cyc);
        check("misaligned_cycles", cyc, 32'd1);
        check("misaligned_traffic", n_valid, 32'd0);

        n_valid = 0;
        run_cmd(1'b0, 32'h100, 32'h500, 16'd2, 32'h0, 1, 5, cyc);
        check("stall_cycles", cyc, 32'd12);
        check("stall_valid_cycles", n_valid, 32'd4);
        check("stall_mem0", mem[32'h500], 32'd1);
        check("stall_mem1", mem[32'h504], 32'd2);

        run_cmd(1'b1, 32'h0, 32'hFFFF_FFFC, 16'd2, 32'h1234_5678, 0, 0, cyc);
        check("wrap_cycles", cyc, 32'd3);
        check("wrap_mem0", mem[32'h0], 32'h1234_5678);

        n_valid = 0;
        run_cmd(1'b0, 32'h100, 32'h600, 16'd0, 32'h0, 0, 0, cyc);
        check("len0_cycles", cyc, 32'd1);
        check("len0_traffic", n_valid, 32'd0);

        // Reset after the second write of a four-word copy.
        model(1'b0, 32'h100, 32'h800, 16'd4, 32'h0);
        base = n_wr;
        start = 1'b1; mode = 1'b0; src = 32'h100; dst = 32'h800; len = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (n_wr < base + 2 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("reset_test_writes", n_wr - base, 32'd2);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {27'h0, busy, done, error, dv, |wstrb}, 32'h0);
        exp_q.delete();
        ev_q.delete();
        ref_mem.delete(32'h808);
        ref_mem.delete(32'h80C);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_cmd(1'b1, 32'h0, 32'h900, 16'd2, 32'hCAFE_F00D, 0, 0, cyc);
        check("post_reset_cycles", cyc, 32'd3);
        check("abandoned_word", {31'h0, mem.exists(32'h808)}, 32'h0);

        for (int t = 0; t < 24; t++) begin
            rs = (t >= 12);
            m  = 1'($urandom);
            n  = $urandom_range(0, 6);
            s  = 32'h1000 + 32'(4 * $urandom_range(0, 63));
            d  = 32'h1000 + 32'(4 * $urandom_range(0, 63));
            if ($urandom_range(0, 5) == 0) d[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) s[1:0] = 2'($urandom_range(1, 3));
            run_cmd(m, s, d, 16'(n), $urandom, 0, rs ? -1 : 0, cyc);
            if (!rs) begin
                if ((!m && s[1:0] != 2'b00) || d[1:0] != 2'b00 || n == 0) exp_cyc = 1;
                else exp_cyc = m ? n + 1 : 3 * n + 1;
                check("rand_cycles", cyc, 32'(exp_cyc));
            end
        end

        check("traffic_left", exp_q.size(), 32'h0);
        check("events_left", ev_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nerv_dmem_dma.md
NERV_DMEM_DMA -- requirements
Module: nerv_dmem_dma

Interface
REQ-001 Parameter LEN_WIDTH, default 16, width of the word-count input and remaining-count register.
REQ-002 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port reset  input  1  reset, asynchronous, active-low.
REQ-004 Port stall  input  1  freeze request; same meaning as the core's stall.
REQ-005 Port start  input  1  single-cycle command strobe, sampled only in IDLE.
REQ-006 Port mode  input  1  0 = copy src->dst, 1 = fill dst with pattern.
REQ-007 Port src_addr  input  32  byte address of first source word.
REQ-008 Port dst_addr  input  32  byte address of first destination word.
REQ-009 Port len  input  LEN_WIDTH  number of 32-bit words to move.
REQ-010 Port pattern  input  32  fill word for mode 1.
REQ-011 Port busy  output  1  high from accepted start until done.
REQ-012 Port done  output  1  one-cycle pulse at command completion.
REQ-013 Port error  output  1  one-cycle pulse, misaligned command rejected.
REQ-014 Ports dmem_valid (out 1), dmem_addr (out 32), dmem_wstrb (out 4), dmem_wdata (out 32), dmem_rdata (in 32): initiator side of the core data-memory interface.

Function
REQ-015 The block SHALL use the dmem protocol as fixed for the core: request presented with dmem_valid in cycle N; read data (wstrb=0) valid on dmem_rdata in cycle N+1 only; write when any wstrb bit set.
REQ-016 States SHALL be IDLE, RD, LAT, WR, FIN.
REQ-017 IDLE + start: if src_addr[1:0]!=0 (copy only) or dst_addr[1:0]!=0 -> pulse error next cycle, stay IDLE, no dmem traffic.
REQ-018 IDLE + start, aligned, len==0 -> FIN (done next cycle), no dmem traffic.
REQ-019 IDLE + start, aligned, len>0: latch addresses, len, mode, pattern; go RD (mode 0) or WR (mode 1); busy=1 next cycle.
REQ-020 RD: dmem_valid=1, dmem_addr=src, wstrb=0; -> LAT.
REQ-021 LAT: dmem_valid=0; buffer<=dmem_rdata; -> WR; LAT SHALL advance and capture even when stall=1.
REQ-022 WR: dmem_valid=1, dmem_addr=dst, wstrb=4'b1111, wdata=buffer (mode 0) or pattern (mode 1); src+=4, dst+=4, remaining-=1; remaining reaching 0 -> FIN, else RD (mode 0) or WR (mode 1).
REQ-023 FIN: done=1 for one cycle, busy drops with it, -> IDLE.
REQ-024 Throughput SHALL be 3 cycles/word copy, 1 cycle/word fill, with stall=0.
REQ-025 In RD and WR with stall=1, dmem_valid SHALL be 0 and state, addresses, count held.
REQ-026 Address increments SHALL wrap modulo 2^32.
REQ-027 start while busy SHALL be ignored; latched parameters SHALL not change mid-command.
REQ-028 Outside RD/WR, dmem_valid=0, dmem_wstrb=0; dmem_addr/wdata don't-care.

Reset
REQ-029 Reset low SHALL immediately force IDLE, busy=0, done=0, error=0, dmem_valid=0, dmem_wstrb=0, counters and addresses 0, including mid-transfer; in-flight word is abandoned.
REQ-030 After reset release, first start is accepted in the first clock edge with reset high.

Verification
REQ-031 Copy: mem[0x100..0x10C]=1,2,3,4; start src=0x100 dst=0x200 len=4 mode=0 -> mem[0x200..0x20C]=1,2,3,4, done exactly 12 cycles after busy rises, 8 dmem_valid cycles.
REQ-032 Fill: dst=0x300 len=3 pattern=0xDEADBEEF -> three writes at 0x300,0x304,0x308 in consecutive cycles, then done.
REQ-033 Misaligned: dst=0x202 -> error pulse 1 cycle, busy stays 0, no dmem_valid.
REQ-034 Stall: stall=1 for 5 cycles during copy of len=2 -> identical memory result, completion delayed exactly 5 cycles, no duplicate or lost writes.
REQ-035 Wrap/len0: dst=0xFFFFFFFC fill len=2 -> writes at 0xFFFFFFFC then 0x00000000; len=0 -> done next cycle, no traffic.
REQ-036 Reset mid-copy (after 2nd write) -> outputs zero within same cycle, no further writes, new command succeeds afterwards.
